rx_lane_deskew: RTL and testbench

- Gen1 multi-lane deskew stage between the PIPE Rx lane inputs and the receive LTSSM/framing block.
- Each active lane is buffered from its first COM symbol (K28.5) onward.
- Once every active lane holds a COM at its buffer head, all lanes are read out in lockstep, so downstream sees ordered sets and framing aligned across lanes.
- Detects excessive skew and loss of alignment, flushes, and re-searches.

---
 rtl/rx_deskew_pkg.sv | 20 ++
 rtl/rx_lane_deskew_if.sv | 27 ++
 rtl/rx_deskew_lane_fifo.sv | 72 +++++++
 rtl/rx_lane_deskew.sv | 108 ++++++++++
 tb/tb_rx_lane_deskew.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rx_deskew_pkg.sv
// Shared types and constants for the Gen1 Rx lane deskew stage.
package rx_deskew_pkg;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } deskew_state_e;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } fifo_entry_t;

    function automatic logic is_com(input fifo_entry_t e);
        return e.k && (e.data == COM_SYMBOL);
    endfunction

endpackage

// File: rtl/rx_lane_deskew_if.sv
// PIPE Rx lane bus in, lane-aligned symbol bus out.
interface rx_lane_deskew_if #(
    parameter int MAXPIPEWIDTH = 32,
    parameter int LANESNUMBER  = 16,
    parameter int LANE_WIDTH   = 8
);
    logic                                  deskew_en;
    logic [4:0]                            numberOfDetectedLanes;
    logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData;
    logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK;
    logic [LANESNUMBER-1:0]                RxValid;
    logic [LANE_WIDTH*LANESNUMBER-1:0]     DeskewData;
    logic [LANESNUMBER-1:0]                DeskewDataK;
    logic [LANESNUMBER-1:0]                DeskewValid;
    logic                                  deskewed;
    logic                                  deskew_error;

    modport master (
        output deskew_en, numberOfDetectedLanes, RxData, RxDataK, RxValid,
        input  DeskewData, DeskewDataK, DeskewValid, deskewed, deskew_error
    );

    modport slave (
        input  deskew_en, numberOfDetectedLanes, RxData, RxDataK, RxValid,
        output DeskewData, DeskewDataK, DeskewValid, deskewed, deskew_error
    );
endinterface

// File: rtl/rx_deskew_lane_fifo.sv
// Per-lane skew FIFO: discards symbols until the first COM, then buffers every valid symbol.
module rx_deskew_lane_fifo
    import rx_deskew_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  fifo_entry_t i_entry,
    input  logic        i_read,
    input  logic        i_flush,
    output logic        o_write,
    output logic        o_empty,
    output logic        o_full,
    output fifo_entry_t o_head
);
    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_com_seen;
    logic               w_push;
    logic               w_pop;

    assign o_write = i_valid && (r_com_seen || is_com(i_entry));
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // Flush wins over any same-cycle write; a full FIFO only accepts when it also pops.
    assign w_push = o_write && !i_flush && (!o_full || i_read);
    assign w_pop  = i_read && !o_empty && !i_flush;

    // NOTE: state uses <= so every register in this edge sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_com_seen <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_com_seen <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_com_seen <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    // NOTE: storage has no reset; the count and pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

endmodule

// File: rtl/rx_lane_deskew.sv
// Gen1 multi-lane deskew: buffers each lane from its first COM and pops all active lanes in lockstep.
module rx_lane_deskew
    import rx_deskew_pkg::*;
#(
    parameter int MAXPIPEWIDTH = 32,
    parameter int LANESNUMBER  = 16,
    parameter int LANE_WIDTH   = 8,
    parameter int DEPTH        = 8
) (
    input  logic            pclk,
    input  logic            reset_n,
    rx_lane_deskew_if.slave bus
);
    localparam int KW = MAXPIPEWIDTH / 8;

    deskew_state_e                   r_state;
    deskew_state_e                   w_state_nxt;
    logic [4:0]                      r_num_lanes;
    logic [LANE_WIDTH*LANESNUMBER-1:0] r_data;
    logic [LANESNUMBER-1:0]          r_data_k;
    logic [LANESNUMBER-1:0]          r_valid;
    logic                            r_error;

    logic [LANESNUMBER-1:0]          w_active;
    logic [LANESNUMBER-1:0]          w_write;
    logic [LANESNUMBER-1:0]          w_empty;
    logic [LANESNUMBER-1:0]          w_full;
    logic [LANESNUMBER-1:0]          w_head_com;
    fifo_entry_t                     w_head [LANESNUMBER];
    logic                            w_ctrl_flush;
    logic                            w_read;
    logic                            w_align_loss;
    logic                            w_overflow;
    logic                            w_error;
    logic                            w_flush;

    for (genvar g = 0; g < LANESNUMBER; g++) begin : g_lane
        fifo_entry_t w_in;

        assign w_active[g] = (bus.numberOfDetectedLanes > 5'(g));
        assign w_in        = '{k: bus.RxDataK[g*KW], data: bus.RxData[g*MAXPIPEWIDTH +: LANE_WIDTH]};

        rx_deskew_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (pclk),
            .rst_n   (reset_n),
            .i_valid (w_active[g] && bus.RxValid[g]),
            .i_entry (w_in),
            .i_read  (w_read && w_active[g]),
            .i_flush (w_flush),
            .o_write (w_write[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g]),
            .o_head  (w_head[g])
        );

        assign w_head_com[g] = w_active[g] && is_com(w_head[g]);
    end

    // A lane-count change behaves like a one-cycle enable drop.
    assign w_ctrl_flush = !bus.deskew_en || (bus.numberOfDetectedLanes != r_num_lanes);
    assign w_read       = !w_ctrl_flush && (w_active != '0) && ((w_active & ~w_empty) == w_active);
    assign w_align_loss = w_read && (r_state == ALIGNED) && (w_head_com != '0) && (w_head_com != w_active);
    assign w_overflow   = !w_ctrl_flush && !w_read && |(w_active & w_full & w_write);
    assign w_error      = w_align_loss || w_overflow;
    assign w_flush      = w_ctrl_flush || w_error;

    // NOTE: next-state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = SEARCH;
        end else if (w_read) begin
            w_state_nxt = ALIGNED;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SEARCH;
            r_num_lanes <= '0;
            r_data      <= '0;
            r_data_k    <= '0;
            r_valid     <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_num_lanes <= bus.numberOfDetectedLanes;
            r_error     <= w_error;
            r_valid     <= '0;
            if (w_read && !w_error) begin
                r_valid <= w_active;
                for (int i = 0; i < LANESNUMBER; i++) begin
                    if (w_active[i]) begin
                        r_data[i*LANE_WIDTH +: LANE_WIDTH] <= w_head[i].data;
                        r_data_k[i]                        <= w_head[i].k;
                    end
                end
            end
        end
    end

    assign bus.DeskewData   = r_data;
    assign bus.DeskewDataK  = r_data_k;
    assign bus.DeskewValid  = r_valid;
    assign bus.deskewed     = (r_state == ALIGNED);
    assign bus.deskew_error = r_error;

endmodule

// File: tb/tb_rx_lane_deskew.sv
// Directed bench for rx_lane_deskew: vector table for lockstep streams plus skew and reset sequences.
module tb_rx_lane_deskew;
    import rx_deskew_pkg::*;

    localparam int LN = 16;
    localparam int NV = 33;

    typedef struct packed {
        logic        en;
        logic [4:0]  n;
        logic [3:0]  v;
        logic [3:0]  k;
        logic [31:0] d;
        logic [15:0] ev;
        logic        edesk;
        logic        eerr;
        logic [3:0]  chk;
        logic [3:0]  ek;
        logic [31:0] ed;
    } vec_t;

    logic pclk    = 1'b0;
    logic reset_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NV];

    always #5 pclk = ~pclk;

    rx_lane_deskew_if #(.MAXPIPEWIDTH(32), .LANESNUMBER(LN), .LANE_WIDTH(8)) bus ();

    rx_lane_deskew #(.MAXPIPEWIDTH(32), .LANESNUMBER(LN), .LANE_WIDTH(8), .DEPTH(8)) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lanes 0-3 come from the arguments; lanes 4-15 always present a valid COM that must be ignored.
    task automatic drive(input logic en, input logic [4:0] n, input logic [3:0] v,
                         input logic [3:0] k, input logic [31:0] d);
        logic [LN*32-1:0] data;
        logic [LN*4-1:0]  kk;
        logic [LN-1:0]    vv;
        data = {LN{32'hA5A5_A5BC}};
        kk   = {LN{4'hF}};
        vv   = '1;
        for (int i = 0; i < 4; i++) begin
            data[i*32 +: 8] = d[i*8 +: 8];
            kk[i*4]         = k[i];
            vv[i]           = v[i];
        end
        bus.deskew_en             = en;
        bus.numberOfDetectedLanes = n;
        bus.RxData                = data;
        bus.RxDataK               = kk;
        bus.RxValid               = vv;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic [4:0] n, input logic [3:0] v,
                                input logic [3:0] k, input logic [31:0] d, input logic [15:0] ev,
                                input logic edesk, input logic eerr, input logic [3:0] chk,
                                input logic [3:0] ek, input logic [31:0] ed);
        vec_t r;
        r.en = en; r.n = n; r.v = v; r.k = k; r.d = d; r.ev = ev;
        r.edesk = edesk; r.eerr = eerr; r.chk = chk; r.ek = ek; r.ed = ed;
        return r;
    endfunction

    task automatic run_skew(input int skew);
        int         errs;
        logic       tol;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] es;
        logic [3:0] kk;
        logic [15:0] exp_v;
        errs = 0;
        tol  = (skew < 8);
        drive(1'b0, 5'd2, 4'hF, 4'h0, 32'h5555_5555);
        tick();
        check($sformatf("skew%0d flush valid", skew), 64'(bus.DeskewValid), 64'(0));
        check($sformatf("skew%0d flush deskewed", skew), 64'(bus.deskewed), 64'(0));
        for (int c = 0; c <= skew + 2; c++) begin
            s0 = (c == 0) ? COM_SYMBOL : 8'(c - 1);
            s1 = (c == skew) ? COM_SYMBOL : (c > skew) ? 8'(c - skew - 1) : 8'h55;
            kk = {2'b00, (c == skew), (c == 0)};
            drive(1'b1, 5'd2, 4'hF, kk, {16'h5555, s1, s0});
            tick();
            exp_v = (tol && c >= skew + 1) ? 16'h0003 : 16'h0000;
            check($sformatf("skew%0d c%0d valid", skew, c), 64'(bus.DeskewValid), 64'(exp_v));
            check($sformatf("skew%0d c%0d error", skew, c), 64'(bus.deskew_error), 64'(!tol && c == 8));
            check($sformatf("skew%0d c%0d deskewed", skew, c), 64'(bus.deskewed), 64'(tol && c >= skew + 1));
            if (exp_v != 16'h0) begin
                es = (c == skew + 1) ? COM_SYMBOL : 8'h00;
                check($sformatf("skew%0d c%0d data", skew, c), 64'(bus.DeskewData[15:0]), 64'({es, es}));
                check($sformatf("skew%0d c%0d k", skew, c), 64'(bus.DeskewDataK[1:0]),
                      64'((c == skew + 1) ? 2'b11 : 2'b00));
            end
            errs += int'(bus.deskew_error);
        end
        check($sformatf("skew%0d error pulses", skew), 64'(errs), 64'(tol ? 0 : 1));
    endtask

    initial begin
        // N=4 entry with lane skews 0..3, mismatched COM on lane 2, clean realign
        vecs[0]  = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h5555_5555, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[1]  = mk(1'b1, 5'd4, 4'hF, 4'h1, 32'h5555_55BC, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[2]  = mk(1'b1, 5'd4, 4'hF, 4'h2, 32'h5555_BC00, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[3]  = mk(1'b1, 5'd4, 4'hF, 4'h4, 32'h55BC_0001, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[4]  = mk(1'b1, 5'd4, 4'hF, 4'h8, 32'hBC00_0102, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[5]  = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h0001_0203, 16'h000F, 1'b1, 1'b0, 4'hF, 4'hF, 32'hBCBC_BCBC);
        vecs[6]  = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h0102_0304, 16'h000F, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0000_0000);
        vecs[7]  = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h0203_0405, 16'h000F, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0101_0101);
        vecs[8]  = mk(1'b1, 5'd4, 4'hF, 4'h1, 32'h0304_05BC, 16'h000F, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0202_0202);
        vecs[9]  = mk(1'b1, 5'd4, 4'hF, 4'h2, 32'h0405_BC07, 16'h000F, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0303_0303);
        vecs[10] = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h0506_0708, 16'h000F, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0404_0404);
        vecs[11] = mk(1'b1, 5'd4, 4'hF, 4'hC, 32'hBCBC_0809, 16'h000F, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0505_0505);
        vecs[12] = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h0708_090A, 16'h0000, 1'b0, 1'b1, 4'h0, 4'h0, 32'h0);
        vecs[13] = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h0809_0A0B, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[14] = mk(1'b1, 5'd4, 4'hF, 4'hF, 32'hBCBC_BCBC, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[15] = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h1111_1111, 16'h000F, 1'b1, 1'b0, 4'hF, 4'hF, 32'hBCBC_BCBC);
        vecs[16] = mk(1'b1, 5'd4, 4'hF, 4'h0, 32'h1212_1212, 16'h000F, 1'b1, 1'b0, 4'hF, 4'h0, 32'h1111_1111);
        // N=2: lane-count change flush, skew 1 entry, 3-cycle stall on lane 1, enable drop, realign
        vecs[17] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_5555, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[18] = mk(1'b1, 5'd2, 4'hF, 4'h1, 32'h5555_55BC, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[19] = mk(1'b1, 5'd2, 4'hF, 4'h2, 32'h5555_BC00, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[20] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_0001, 16'h0003, 1'b1, 1'b0, 4'h3, 4'h3, 32'h0000_BCBC);
        vecs[21] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_0102, 16'h0003, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0000_0000);
        vecs[22] = mk(1'b1, 5'd2, 4'hD, 4'h0, 32'h5555_5503, 16'h0003, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0000_0101);
        vecs[23] = mk(1'b1, 5'd2, 4'hD, 4'h0, 32'h5555_5504, 16'h0000, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[24] = mk(1'b1, 5'd2, 4'hD, 4'h0, 32'h5555_5505, 16'h0000, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[25] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_0206, 16'h0000, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[26] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_0307, 16'h0003, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0000_0202);
        vecs[27] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_0408, 16'h0003, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0000_0303);
        vecs[28] = mk(1'b0, 5'd2, 4'hF, 4'h0, 32'h5555_0509, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[29] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_060A, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[30] = mk(1'b1, 5'd2, 4'hF, 4'h3, 32'h5555_BCBC, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        vecs[31] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_2020, 16'h0003, 1'b1, 1'b0, 4'h3, 4'h3, 32'h0000_BCBC);
        vecs[32] = mk(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_2121, 16'h0003, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0000_2020);

        drive(1'b1, 5'd4, 4'hF, 4'h0, 32'h5555_5555);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset valid", 64'(bus.DeskewValid), 64'(0));
        check("reset data lo", bus.DeskewData[63:0], 64'(0));
        check("reset data hi", bus.DeskewData[127:64], 64'(0));
        check("reset k", 64'(bus.DeskewDataK), 64'(0));
        check("reset deskewed", 64'(bus.deskewed), 64'(0));
        check("reset error", 64'(bus.deskew_error), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            drive(vecs[r].en, vecs[r].n, vecs[r].v, vecs[r].k, vecs[r].d);
            tick();
            check($sformatf("row%0d valid", r), 64'(bus.DeskewValid), 64'(vecs[r].ev));
            check($sformatf("row%0d deskewed", r), 64'(bus.deskewed), 64'(vecs[r].edesk));
            check($sformatf("row%0d error", r), 64'(bus.deskew_error), 64'(vecs[r].eerr));
            for (int i = 0; i < 4; i++) begin
                if (vecs[r].chk[i]) begin
                    check($sformatf("row%0d lane%0d data", r, i), 64'(bus.DeskewData[i*8 +: 8]),
                          64'(vecs[r].ed[i*8 +: 8]));
                    check($sformatf("row%0d lane%0d k", r, i), 64'(bus.DeskewDataK[i]), 64'(vecs[r].ek[i]));
                end
            end
        end

        run_skew(8);
        run_skew(1);
        run_skew(7);

        // Asynchronous reset in the middle of an aligned stream
        drive(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_3030);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst valid", 64'(bus.DeskewValid), 64'(0));
        check("midrst data", bus.DeskewData[63:0], 64'(0));
        check("midrst deskewed", 64'(bus.deskewed), 64'(0));
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd2, 4'hF, 4'h0, 32'h5555_4141);
            tick();
            check($sformatf("idle%0d valid", c), 64'(bus.DeskewValid), 64'(0));
            check($sformatf("idle%0d deskewed", c), 64'(bus.deskewed), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
